// File: rtl/irq_pkg.sv
// Purpose : shared defaults and FSM encoding for the interrupt pending controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package irq_pkg;

  localparam int N_REQ_DEF = 8;
  localparam int ID_W_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } irq_state_e;

  // One-hot of an index; indices beyond the vector width give all-zero.
  function automatic logic [N_REQ_DEF-1:0] idx_onehot(input logic [ID_W_DEF-1:0] idx);
    idx_onehot = N_REQ_DEF'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Purpose : per-line multi-flop synchroniser followed by a rising-edge or level event detector.
// Latency : SYNC_STAGES cycles from req_i to the synchronised level; ev_o is combinational on it.
// Backpressure: none; events are single-cycle pulses (edge mode) or follow the level.
// Ports   : clk, rst_n (async, active-low), req_i [WIDTH] async requests, ev_o [WIDTH] events.
module irq_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] ev_o
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_req_d;
  logic [WIDTH-1:0] w_req_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_req_d <= '0;
    end else begin
      r_sync[0] <= req_i;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_req_d <= w_req_s;
    end
  end

  assign w_req_s = r_sync[SYNC_STAGES-1];

  // Edge mode produces one pulse per low-to-high transition of the synchronised line.
  assign ev_o = (EDGE_MODE != 0) ? (w_req_s & ~r_req_d) : w_req_s;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Purpose : collects synchronised request events into a pending register, masks them and offers a
//           frozen snapshot (pend_o/valid_o) to a priority encoder; an ack clears the serviced bit.
// Latency : req_i to pending SYNC_STAGES+1 (edge mode); pending to valid_o 1; ack to next valid_o 2.
// Backpressure: an offer is held until ack_i; new events keep accumulating in pending meanwhile.
// Ports   : clk, rst_n, req_i, mask_i, ack_i, ack_id_i, clr_ovf_i in; pend_o, valid_o, ovf_o, err_o out.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int ID_W        = ID_W_DEF,   // 2**ID_W must cover N_REQ
  parameter int SYNC_STAGES = 2,          // at least 2
  parameter int EDGE_MODE   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  input  logic             ack_i,
  input  logic [ID_W-1:0]  ack_id_i,
  input  logic             clr_ovf_i,
  output logic [N_REQ-1:0] pend_o,
  output logic             valid_o,
  output logic [N_REQ-1:0] ovf_o,
  output logic             err_o
);

  logic [N_REQ-1:0] w_ev;
  logic [N_REQ-1:0] r_pend;
  logic [N_REQ-1:0] r_snap;
  logic [N_REQ-1:0] r_ovf;
  logic             r_valid;
  logic             r_err;
  irq_state_e       r_state;
  irq_state_e       w_state_nxt;

  logic [N_REQ-1:0] w_onehot;
  logic             w_id_in_range;
  logic             w_ack_ok;
  logic             w_load;
  logic [N_REQ-1:0] w_clr;
  logic             w_err_nxt;

  irq_sync_edge #(
    .WIDTH       (N_REQ),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_MODE   (EDGE_MODE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_i),
    .ev_o  (w_ev)
  );

  // Shifting past the vector width yields zero, so an out-of-range id never hits the snapshot.
  assign w_onehot      = N_REQ'(1) << ack_id_i;
  assign w_id_in_range = ({1'b0, ack_id_i} < (ID_W+1)'(N_REQ));
  assign w_ack_ok      = w_id_in_range && (|(r_snap & w_onehot));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (|(r_pend & mask_i)) w_state_nxt = ST_OFFER;
      ST_OFFER: if (ack_i)              w_state_nxt = ST_GAP;
      ST_GAP:                           w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control: snapshot load, pending clear, error pulse
  always_comb begin
    w_load    = 1'b0;
    w_clr     = '0;
    w_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE:  w_load = |(r_pend & mask_i);
      ST_OFFER: begin
        if (ack_i) begin
          if (w_ack_ok) w_clr     = w_onehot;
          else          w_err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_snap  <= '0;
      r_ovf   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // An event on a bit being cleared keeps it set.
      r_pend  <= (r_pend & ~w_clr) | w_ev;
      // A new overflow outranks a simultaneous clr_ovf_i.
      r_ovf   <= (r_ovf & {N_REQ{~clr_ovf_i}}) | (w_ev & r_pend & ~w_clr);
      r_valid <= (w_state_nxt == ST_OFFER);
      r_err   <= w_err_nxt;
      // Snapshot is frozen through OFFER and zero otherwise so no stale data reaches the encoder.
      if (w_load)                        r_snap <= r_pend & mask_i;
      else if (w_state_nxt != ST_OFFER)  r_snap <= '0;
    end
  end

  assign pend_o  = r_snap;
  assign valid_o = r_valid;
  assign ovf_o   = r_ovf;
  assign err_o   = r_err;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Purpose : directed self-checking bench for irq_pending_ctrl (default parameters, edge mode).
// Latency : n/a.
// Backpressure: n/a.
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_i;
  logic [7:0] mask_i;
  logic       ack_i;
  logic [2:0] ack_id_i;
  logic       clr_ovf_i;
  logic [7:0] pend_o;
  logic       valid_o;
  logic [7:0] ovf_o;
  logic       err_o;

  int n_vec;
  int n_err;

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .mask_i    (mask_i),
    .ack_i     (ack_i),
    .ack_id_i  (ack_id_i),
    .clr_ovf_i (clr_ovf_i),
    .pend_o    (pend_o),
    .valid_o   (valid_o),
    .ovf_o     (ovf_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle request pulse on the given lines.
  task automatic pulse_req(input logic [7:0] lines);
    req_i = lines;
    tick();
    req_i = '0;
  endtask

  task automatic do_ack(input logic [2:0] id);
    ack_i    = 1'b1;
    ack_id_i = id;
    tick();
    ack_i    = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_i     = '0;
    mask_i    = 8'hFF;
    ack_i     = 1'b0;
    ack_id_i  = '0;
    clr_ovf_i = 1'b0;
    tick(3);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_pend",  pend_o,  8'h00);
    chk("rst_ovf",   ovf_o,   8'h00);
    chk("rst_err",   err_o,   1'b0);
    rst_n = 1'b1;
    tick(2);

    // Single request: offer appears SYNC_STAGES+2 = 4 edges after the pulse is applied.
    pulse_req(8'h20);
    tick(2);
    chk("t1_valid_early", valid_o, 1'b0);
    tick();
    chk("t1_valid", valid_o, 1'b1);
    chk("t1_pend",  pend_o,  8'h20);
    do_ack(3'd5);
    chk("t1_gap_valid", valid_o, 1'b0);
    chk("t1_gap_pend",  pend_o,  8'h00);
    chk("t1_gap_err",   err_o,   1'b0);
    tick(3);
    chk("t1_idle_valid", valid_o, 1'b0);

    // Two simultaneous requests; lower-priority leftover re-offered after GAP+IDLE.
    pulse_req(8'h42);
    tick(3);
    chk("t2_valid", valid_o, 1'b1);
    chk("t2_pend",  pend_o,  8'h42);
    do_ack(3'd6);
    chk("t2_gap_valid", valid_o, 1'b0);
    tick();
    chk("t2_idle_valid", valid_o, 1'b0);
    tick();
    chk("t2_reoffer_valid", valid_o, 1'b1);
    chk("t2_reoffer_pend",  pend_o,  8'h02);
    do_ack(3'd1);
    tick(3);
    chk("t2_drained_valid", valid_o, 1'b0);
    chk("t2_drained_pend",  pend_o,  8'h00);

    // Snapshot is frozen while a new request arrives.
    pulse_req(8'h08);
    tick(3);
    chk("t3_pend", pend_o, 8'h08);
    pulse_req(8'h80);
    tick(4);
    chk("t3_frozen_pend",  pend_o,  8'h08);
    chk("t3_frozen_valid", valid_o, 1'b1);
    do_ack(3'd3);
    tick(2);
    chk("t3_next_pend", pend_o, 8'h80);
    do_ack(3'd7);
    tick(3);
    chk("t3_drained_valid", valid_o, 1'b0);

    // Masked line produces no offer until the mask opens.
    mask_i = 8'h0F;
    pulse_req(8'h10);
    tick(5);
    chk("t4_masked_valid", valid_o, 1'b0);
    mask_i = 8'hFF;
    tick();
    chk("t4_unmask_valid", valid_o, 1'b1);
    chk("t4_unmask_pend",  pend_o,  8'h10);
    do_ack(3'd4);
    tick(3);
    chk("t4_drained_valid", valid_o, 1'b0);

    // Ack of an index not in the snapshot: single err pulse, bit kept, re-offer.
    pulse_req(8'h08);
    tick(3);
    chk("t5_pend", pend_o, 8'h08);
    do_ack(3'd2);
    chk("t5_err",        err_o,   1'b1);
    chk("t5_gap_valid",  valid_o, 1'b0);
    tick();
    chk("t5_err_once",   err_o,   1'b0);
    tick();
    chk("t5_reoffer_valid", valid_o, 1'b1);
    chk("t5_reoffer_pend",  pend_o,  8'h08);
    do_ack(3'd3);
    chk("t5_good_ack_err", err_o, 1'b0);
    tick(3);
    chk("t5_drained_valid", valid_o, 1'b0);

    // Overflow: second event on a pending line; sticky until clr_ovf_i.
    pulse_req(8'h01);
    tick(3);
    chk("t6_pend", pend_o, 8'h01);
    chk("t6_ovf_before", ovf_o, 8'h00);
    tick();
    pulse_req(8'h01);
    tick(3);
    chk("t6_ovf", ovf_o, 8'h01);
    do_ack(3'd0);
    tick(2);
    chk("t6_ovf_sticky", ovf_o,   8'h01);
    chk("t6_no_reoffer", valid_o, 1'b0);
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    chk("t6_ovf_cleared", ovf_o, 8'h00);

    // Asynchronous reset in the middle of an offer.
    pulse_req(8'h04);
    tick(4);
    pulse_req(8'h04);
    tick(3);
    chk("t7_valid", valid_o, 1'b1);
    chk("t7_ovf",   ovf_o,   8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", valid_o, 1'b0);
    chk("t7_rst_pend",  pend_o,  8'h00);
    chk("t7_rst_ovf",   ovf_o,   8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("t7_after_rst_valid", valid_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global safety net in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
